// File: rtl/ycbcr_pkg.sv
// Shared constants and pixel packing helpers for the YCbCr frame buffer.
package ycbcr_pkg;

    localparam int unsigned CH_Y       = 0;
    localparam int unsigned CH_CB      = 1;
    localparam int unsigned CH_CR      = 2;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CH_DEF     = 3;

    // Extract channel c from a default-sized pixel word.
    function automatic logic [DATA_W_DEF-1:0] get_ch(
        input logic [CH_DEF*DATA_W_DEF-1:0] pix,
        input int unsigned                  c
    );
        return pix[c*DATA_W_DEF +: DATA_W_DEF];
    endfunction

    // Build a default-sized pixel word from its three components.
    function automatic logic [CH_DEF*DATA_W_DEF-1:0] pack_pix(
        input logic [DATA_W_DEF-1:0] y,
        input logic [DATA_W_DEF-1:0] cb,
        input logic [DATA_W_DEF-1:0] cr
    );
        logic [CH_DEF*DATA_W_DEF-1:0] p;
        p = '0;
        p[CH_Y*DATA_W_DEF  +: DATA_W_DEF] = y;
        p[CH_CB*DATA_W_DEF +: DATA_W_DEF] = cb;
        p[CH_CR*DATA_W_DEF +: DATA_W_DEF] = cr;
        return p;
    endfunction

endpackage

// File: rtl/ycbcr_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module ycbcr_sdp_ram
    import ycbcr_pkg::*;
#(
    parameter  int unsigned WIDTH  = CH_DEF*DATA_W_DEF,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store a whole pixel when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port: output holds when no read is requested.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ycbcr_frame_buf.sv
// Multi-channel circular pixel buffer with flow control, occupancy and sticky error flags.
module ycbcr_frame_buf
    import ycbcr_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned CH     = CH_DEF,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [CH*DATA_W-1:0] wr_data,
    input  logic                 rd_en,
    output logic [CH*DATA_W-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_W:0]      count,
    output logic                 ovf,
    output logic                 udf,
    input  logic                 clr_err
);

    localparam int unsigned     PIX_W     = CH*DATA_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              data_ok;
    logic [PIX_W-1:0]  ram_q;

    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign wr_acc = enable & wr_en & ~full;
    assign rd_acc = enable & rd_en & ~empty;

    // Both accepted implies 0 < count < DEPTH, so the two ports never hit the same entry.
    ycbcr_sdp_ram #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // The RAM output register has no reset; data_ok masks it to zero until a read lands after reset/clear.
    assign rd_data = data_ok ? ram_q : '0;

    // Pointer, occupancy, read-valid and sticky-flag state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            data_ok  <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else if (!enable) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            data_ok  <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                data_ok <= 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            rd_valid <= rd_acc;
            ovf      <= ~clr_err & (ovf | (wr_en & full));
            udf      <= ~clr_err & (udf | (rd_en & empty));
        end
    end

endmodule
